// File: rtl/acc_alu_seq_if.sv
// Request/response bundle between the accumulator datapath and acc_alu_seq.
interface acc_alu_seq_if #(
    parameter int data_width = 16
);
    logic                  start;
    logic [1:0]            op;
    logic [data_width-1:0] a;
    logic [data_width-1:0] b;
    logic [data_width-1:0] result;
    logic                  ac_we;
    logic                  busy;
    logic                  overflow;

    modport master (
        output start, op, a, b,
        input  result, ac_we, busy, overflow
    );

    modport slave (
        input  start, op, a, b,
        output result, ac_we, busy, overflow
    );
endinterface

// File: rtl/acc_alu_seq.sv
// Sequential ALU feeding an accumulator: single-cycle PASS/ADD/SUB and a
// data_width-iteration unsigned shift-add MUL on operands latched at start.
module acc_alu_seq #(
    parameter int data_width = 16
) (
    input  logic         clk,
    input  logic         rst,
    acc_alu_seq_if.slave alu
);
    localparam int W  = data_width;
    localparam int CW = (W > 1) ? $clog2(W) : 1;

    localparam logic [1:0] OP_PASS = 2'b00;
    localparam logic [1:0] OP_ADD  = 2'b01;
    localparam logic [1:0] OP_SUB  = 2'b10;

    typedef enum logic {
        ST_IDLE,
        ST_MUL
    } state_t;

    state_t         state;
    logic [W-1:0]   a_q;
    logic [W-1:0]   b_q;
    logic [2*W-1:0] product;
    logic [CW-1:0]  count;
    logic [W-1:0]   result_q;
    logic           ac_we_q;
    logic           busy_q;
    logic           overflow_q;

    logic [W:0]     sum_ext;
    logic [W:0]     diff_ext;
    logic [2*W-1:0] addend;
    logic [2*W-1:0] product_next;

    // The extra top bit of the widened subtraction is the borrow (a < b).
    assign sum_ext      = {1'b0, alu.a} + {1'b0, alu.b};
    assign diff_ext     = {1'b0, alu.a} - {1'b0, alu.b};
    assign addend       = b_q[count] ? ({{W{1'b0}}, a_q} << count) : '0;
    assign product_next = product + addend;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            a_q        <= '0;
            b_q        <= '0;
            product    <= '0;
            count      <= '0;
            result_q   <= '0;
            ac_we_q    <= 1'b0;
            busy_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            ac_we_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (alu.start) begin
                        a_q <= alu.a;
                        b_q <= alu.b;
                        case (alu.op)
                            OP_PASS: begin
                                result_q   <= alu.b;
                                overflow_q <= 1'b0;
                                ac_we_q    <= 1'b1;
                            end
                            OP_ADD: begin
                                result_q   <= sum_ext[W-1:0];
                                overflow_q <= sum_ext[W];
                                ac_we_q    <= 1'b1;
                            end
                            OP_SUB: begin
                                result_q   <= diff_ext[W-1:0];
                                overflow_q <= diff_ext[W];
                                ac_we_q    <= 1'b1;
                            end
                            default: begin
                                state   <= ST_MUL;
                                busy_q  <= 1'b1;
                                count   <= '0;
                                product <= '0;
                            end
                        endcase
                    end
                end
                ST_MUL: begin
                    // Fixed-length loop: every bit of b is visited, no early exit.
                    product <= product_next;
                    count   <= count + 1'b1;
                    if (count == CW'(W - 1)) begin
                        result_q   <= product_next[W-1:0];
                        overflow_q <= |product_next[2*W-1:W];
                        ac_we_q    <= 1'b1;
                        busy_q     <= 1'b0;
                        state      <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign alu.result   = result_q;
    assign alu.ac_we    = ac_we_q;
    assign alu.busy     = busy_q;
    assign alu.overflow = overflow_q;
endmodule

// File: tb/tb_acc_alu_seq.sv
// Directed bench for acc_alu_seq: a per-cycle arithmetic reference model plus
// literal checks, with a small accumulator register closing the loop on a.
module tb_acc_alu_seq;
    localparam int W = 16;
    localparam longint MOD = longint'(1) << W;

    localparam logic [1:0] OP_PASS = 2'b00;
    localparam logic [1:0] OP_ADD  = 2'b01;
    localparam logic [1:0] OP_SUB  = 2'b10;
    localparam logic [1:0] OP_MUL  = 2'b11;

    logic clk = 1'b0;
    logic rst;

    acc_alu_seq_if #(.data_width(W)) bus ();

    acc_alu_seq #(.data_width(W)) dut (
        .clk (clk),
        .rst (rst),
        .alu (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [W-1:0] acc;
    logic         z;
    logic         use_acc = 1'b0;
    logic [W-1:0] a_drv   = '0;

    assign bus.a = use_acc ? acc : a_drv;
    assign z     = (acc == '0);

    always @(posedge clk or posedge rst) begin
        if (rst)
            acc <= '0;
        else if (bus.ac_we)
            acc <= bus.result;
    end

    function automatic logic [W:0] ref_op(input logic [1:0] op, input longint a, input longint b);
        longint r;
        logic   ov;
        case (op)
            OP_PASS: begin r = b;     ov = 1'b0;       end
            OP_ADD:  begin r = a + b; ov = (r >= MOD); end
            OP_SUB:  begin r = a - b; ov = (a < b);    end
            default: begin r = a * b; ov = (r >= MOD); end
        endcase
        r = ((r % MOD) + MOD) % MOD;
        return {ov, r[W-1:0]};
    endfunction

    logic [W-1:0] m_result = '0;
    logic         m_over   = 1'b0;
    logic         m_we     = 1'b0;
    logic         m_busy   = 1'b0;
    logic [W:0]   m_pend   = '0;
    int           m_left   = 0;

    // Reference: single ops complete at the start edge, MUL exactly W edges later.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_result <= '0;
            m_over   <= 1'b0;
            m_we     <= 1'b0;
            m_busy   <= 1'b0;
            m_pend   <= '0;
            m_left   <= 0;
        end else begin
            m_we <= 1'b0;
            if (m_left != 0) begin
                m_left <= m_left - 1;
                if (m_left == 1) begin
                    {m_over, m_result} <= m_pend;
                    m_we   <= 1'b1;
                    m_busy <= 1'b0;
                end
            end else if (bus.start) begin
                if (bus.op == OP_MUL) begin
                    m_pend <= ref_op(OP_MUL, longint'(bus.a), longint'(bus.b));
                    m_left <= W;
                    m_busy <= 1'b1;
                end else begin
                    {m_over, m_result} <= ref_op(bus.op, longint'(bus.a), longint'(bus.b));
                    m_we <= 1'b1;
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    logic cmp_en = 1'b0;

    always @(negedge clk) begin
        if (cmp_en) begin
            checkOutput("cyc_result",   32'(bus.result),   32'(m_result));
            checkOutput("cyc_overflow", 32'(bus.overflow), 32'(m_over));
            checkOutput("cyc_ac_we",    32'(bus.ac_we),    32'(m_we));
            checkOutput("cyc_busy",     32'(bus.busy),     32'(m_busy));
        end
    end

    task automatic applyStimulus(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        bus.start = 1'b1;
        bus.op    = op;
        a_drv     = a;
        bus.b     = b;
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    task automatic waitForWe(input int limit, output int edges);
        edges = 0;
        while (!bus.ac_we && edges < limit) begin
            @(posedge clk); #1;
            edges++;
        end
        checkOutput("we_within_bound", 32'(bus.ac_we), 32'd1);
    endtask

    task automatic countPulses(input int cycles, output int n);
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk); #1;
            if (bus.ac_we) n++;
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int e;
        int n;

        bus.start = 1'b0;
        bus.op    = OP_PASS;
        bus.b     = '0;
        a_drv     = '0;
        rst       = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst    = 1'b0;
        cmp_en = 1'b1;

        checkOutput("reset_result",   32'(bus.result),   32'h0);
        checkOutput("reset_ac_we",    32'(bus.ac_we),    32'h0);
        checkOutput("reset_busy",     32'(bus.busy),     32'h0);
        checkOutput("reset_overflow", 32'(bus.overflow), 32'h0);

        applyStimulus(OP_PASS, 16'h0000, 16'h1234);
        checkOutput("pass_result",   32'(bus.result),   32'h1234);
        checkOutput("pass_ac_we",    32'(bus.ac_we),    32'h1);
        checkOutput("pass_overflow", 32'(bus.overflow), 32'h0);
        checkOutput("pass_busy",     32'(bus.busy),     32'h0);
        @(posedge clk); #1;
        checkOutput("pass_we_drops", 32'(bus.ac_we),    32'h0);
        checkOutput("pass_hold",     32'(bus.result),   32'h1234);

        bus.start = 1'b1;
        bus.op    = OP_ADD;
        a_drv     = 16'hFFFF;
        bus.b     = 16'h0002;
        @(posedge clk); #1;
        checkOutput("add_result",   32'(bus.result),   32'h0001);
        checkOutput("add_overflow", 32'(bus.overflow), 32'h1);
        checkOutput("add_ac_we",    32'(bus.ac_we),    32'h1);
        bus.op = OP_SUB;
        a_drv  = 16'h0003;
        bus.b  = 16'h0005;
        @(posedge clk); #1;
        bus.start = 1'b0;
        checkOutput("sub_result",   32'(bus.result),   32'hFFFE);
        checkOutput("sub_overflow", 32'(bus.overflow), 32'h1);
        checkOutput("sub_ac_we",    32'(bus.ac_we),    32'h1);
        @(posedge clk); #1;
        checkOutput("b2b_we_drops", 32'(bus.ac_we),    32'h0);

        applyStimulus(OP_MUL, 16'h00FF, 16'h0101);
        checkOutput("mul1_busy", 32'(bus.busy),  32'h1);
        checkOutput("mul1_no_we", 32'(bus.ac_we), 32'h0);
        a_drv     = 16'h0000;
        bus.b     = 16'h0000;
        bus.op    = OP_PASS;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        waitForWe(40, e);
        checkOutput("mul1_latency_edges", 32'(2 + e),        32'(W + 1));
        checkOutput("mul1_result",        32'(bus.result),   32'hFFFF);
        checkOutput("mul1_overflow",      32'(bus.overflow), 32'h0);
        checkOutput("mul1_busy_done",     32'(bus.busy),     32'h0);
        countPulses(20, n);
        checkOutput("mul1_ignored_start", 32'(n), 32'd0);

        applyStimulus(OP_MUL, 16'h0100, 16'h0100);
        waitForWe(40, e);
        checkOutput("mul2_latency_edges", 32'(1 + e),        32'(W + 1));
        checkOutput("mul2_result",        32'(bus.result),   32'h0000);
        checkOutput("mul2_overflow",      32'(bus.overflow), 32'h1);
        applyStimulus(OP_MUL, 16'h0000, 16'hFFFF);
        checkOutput("mul3_accepted_busy", 32'(bus.busy), 32'h1);
        waitForWe(40, e);
        checkOutput("mul3_latency_edges", 32'(1 + e),        32'(W + 1));
        checkOutput("mul3_result",        32'(bus.result),   32'h0000);
        checkOutput("mul3_overflow",      32'(bus.overflow), 32'h0);
        @(posedge clk); #1;

        applyStimulus(OP_ADD, 16'hFFFF, 16'h0002);
        applyStimulus(OP_MUL, 16'h00FF, 16'h0101);
        repeat (8) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        checkOutput("rst_mid_busy",     32'(bus.busy),     32'h0);
        checkOutput("rst_mid_result",   32'(bus.result),   32'h0);
        checkOutput("rst_mid_overflow", 32'(bus.overflow), 32'h0);
        checkOutput("rst_mid_ac_we",    32'(bus.ac_we),    32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        countPulses(20, n);
        checkOutput("rst_aborted_no_we", 32'(n), 32'd0);
        applyStimulus(OP_PASS, 16'h0000, 16'h00AB);
        checkOutput("post_rst_pass_result", 32'(bus.result), 32'h00AB);
        checkOutput("post_rst_pass_we",     32'(bus.ac_we),  32'h1);
        @(posedge clk); #1;

        use_acc = 1'b1;
        applyStimulus(OP_PASS, 16'h0000, 16'h0005);
        waitForWe(4, e);
        @(posedge clk); #1;
        checkOutput("chain_acc_pass", 32'(acc), 32'h0005);
        applyStimulus(OP_ADD, 16'h0000, 16'h0007);
        waitForWe(4, e);
        @(posedge clk); #1;
        checkOutput("chain_acc_add", 32'(acc), 32'h000C);
        applyStimulus(OP_MUL, 16'h0000, 16'h0003);
        waitForWe(40, e);
        @(posedge clk); #1;
        checkOutput("chain_acc_mul", 32'(acc), 32'h0024);
        checkOutput("chain_z_mul",   32'(z),   32'h0);
        applyStimulus(OP_SUB, 16'h0000, 16'h0024);
        waitForWe(4, e);
        checkOutput("chain_sub_result", 32'(bus.result), 32'h0000);
        @(posedge clk); #1;
        checkOutput("chain_acc_sub", 32'(acc), 32'h0000);
        checkOutput("chain_z_sub",   32'(z),   32'h1);
        use_acc = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
